// File: rtl/irq_pend_ctrl_pkg.sv
// Shared constants and FSM encoding for the interrupt pending controller.
package irq_pend_ctrl_pkg;
  localparam int NUM_LINES = 8;
  localparam int ID_W      = 3;
  localparam int LOST_W    = 4;
  localparam int LOST_MAX  = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_GAP   = 2'd2
  } irq_state_e;
endpackage

// File: rtl/irq_pend_ctrl_if.sv
// Request/service bundle between the interrupt sources/consumer and the controller.
interface irq_pend_ctrl_if;
  import irq_pend_ctrl_pkg::*;
  logic [NUM_LINES-1:0] req;
  logic [NUM_LINES-1:0] mask;
  logic                 ack;
  logic [NUM_LINES-1:0] pend_o;
  logic                 en_o;
  logic                 irq_o;
  logic [ID_W-1:0]      id_o;
  logic [LOST_W-1:0]    lost_o;

  modport slave  (input  req, mask, ack, output pend_o, en_o, irq_o, id_o, lost_o);
  modport master (output req, mask, ack, input  pend_o, en_o, irq_o, id_o, lost_o);
endinterface

// File: rtl/irq_edge_det.sv
// Per-line 2-flop synchronizer plus edge register; emits a one-cycle rising-edge pulse.
module irq_edge_det #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_req,
  output logic [W-1:0] o_edge
);
  logic [W-1:0] r_sync1, r_sync2, r_edge;
  // Edge output is held off until the edge register has tracked a real
  // post-reset sample, so a line already high at release is not an edge.
  logic [1:0]   r_settle;

  // Synchronizer chain and settle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_edge   <= '0;
      r_settle <= '0;
    end else begin
      r_sync1 <= i_req;
      r_sync2 <= r_sync1;
      r_edge  <= r_sync2;
      if (r_settle != 2'd3) r_settle <= r_settle + 2'd1;
    end
  end

  assign o_edge = (r_settle == 2'd3) ? (r_sync2 & ~r_edge) : '0;
endmodule

// File: rtl/irq_pend_ctrl.sv
// Edge-latched interrupt pending register with priority select, ack handshake
// and saturating lost-edge counter.
module irq_pend_ctrl
  import irq_pend_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  irq_pend_ctrl_if.slave bus
);
  irq_state_e           r_state, w_state_nxt;
  logic [NUM_LINES-1:0] r_pending, r_pend_o;
  logic                 r_en_o;
  logic [ID_W-1:0]      r_id;
  logic [LOST_W-1:0]    r_lost;
  logic [NUM_LINES-1:0] w_edge, w_clr, w_avail, w_drop;
  logic                 w_load_id;
  logic [LOST_W:0]      w_lost_sum;

  function automatic logic [ID_W-1:0] f_hi_idx(input logic [NUM_LINES-1:0] v);
    f_hi_idx = '0;
    for (int i = 0; i < NUM_LINES; i++)
      if (v[i]) f_hi_idx = ID_W'(i);
  endfunction

  irq_edge_det #(.W(NUM_LINES)) u_edge (
    .clk    (clk),
    .rst    (rst),
    .i_req  (bus.req),
    .o_edge (w_edge)
  );

  assign w_avail    = r_pending & bus.mask;
  // A new edge on the bit being cleared wins and is not a loss.
  assign w_drop     = w_edge & r_pending & ~w_clr;
  assign w_lost_sum = {1'b0, r_lost} + (LOST_W+1)'($countones(w_drop));

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next state, id load and ack clear
  always_comb begin
    w_state_nxt = r_state;
    w_load_id   = 1'b0;
    w_clr       = '0;
    case (r_state)
      ST_IDLE: if (|w_avail) begin
        w_load_id   = 1'b1;
        w_state_nxt = ST_SERVE;
      end
      ST_SERVE: if (bus.ack) begin
        w_clr       = NUM_LINES'(1) << r_id;
        w_state_nxt = ST_GAP;
      end
      ST_GAP:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Pending latch, registered outputs, in-service id and lost counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= '0;
      r_pend_o  <= '0;
      r_en_o    <= 1'b0;
      r_id      <= '0;
      r_lost    <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_edge;
      r_pend_o  <= w_avail;
      r_en_o    <= |w_avail;
      if (w_load_id) r_id <= f_hi_idx(w_avail);
      if (w_lost_sum > (LOST_W+1)'(LOST_MAX)) r_lost <= LOST_W'(LOST_MAX);
      else                                   r_lost <= w_lost_sum[LOST_W-1:0];
    end
  end

  assign bus.pend_o = r_pend_o;
  assign bus.en_o   = r_en_o;
  assign bus.irq_o  = (r_state == ST_SERVE);
  assign bus.id_o   = r_id;
  assign bus.lost_o = r_lost;
endmodule

// File: tb/tb_irq_pend_ctrl.sv
// Randomized + directed bench: a cycle-level reference model pushes expected
// outputs per clock; a negedge monitor pops and compares.
module tb_irq_pend_ctrl;
  logic clk = 1'b0;
  logic rst;
  irq_pend_ctrl_if ifc ();

  irq_pend_ctrl dut (.clk(clk), .rst(rst), .bus(ifc));

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] pend;
    logic       en;
    logic       irq;
    logic [2:0] id;
    logic [3:0] lost;
  } exp_t;

  exp_t sbq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: service mode 0=idle, 1=serving, 2=one-cycle gap
  bit [7:0] m_pend;
  int       m_mode, m_id, m_lost;
  bit [7:0] m_hist[$];   // last three post-reset samples of req
  bit [7:0] m_pend_o;
  bit       m_en;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model(input bit [7:0] r, input bit [7:0] m, input bit a, input bit rs);
    bit [7:0] e, clr, avail;
    if (rs) begin
      m_pend = '0; m_mode = 0; m_id = 0; m_lost = 0;
      m_hist.delete(); m_pend_o = '0; m_en = 1'b0;
      return;
    end
    // A rise is a low sample followed by a high sample, both taken after reset,
    // taking effect two clocks after the high sample.
    e = '0;
    if (m_hist.size() >= 3) e = m_hist[m_hist.size()-2] & ~m_hist[m_hist.size()-3];
    clr = '0;
    if (m_mode == 1 && a) clr = 8'b1 << m_id;
    m_lost += $countones(e & m_pend & ~clr);
    if (m_lost > 15) m_lost = 15;
    avail    = m_pend & m;
    m_pend_o = avail;
    m_en     = (avail != 0);
    if (m_mode == 1) begin
      if (a) m_mode = 2;
    end else if (m_mode == 2) m_mode = 0;
    else if (avail != 0) begin
      for (int i = 0; i < 8; i++) if (avail[i]) m_id = i;
      m_mode = 1;
    end
    m_pend = (m_pend & ~clr) | e;
    m_hist.push_back(r);
    if (m_hist.size() > 3) void'(m_hist.pop_front());
  endtask

  task automatic step(input logic [7:0] r, input logic [7:0] m, input logic a, input logic rs);
    exp_t x;
    ifc.req = r; ifc.mask = m; ifc.ack = a; rst = rs;
    model(r, m, a, rs);
    x.pend = m_pend_o; x.en = m_en; x.irq = (m_mode == 1);
    x.id = 3'(m_id); x.lost = 4'(m_lost);
    @(posedge clk);
    sbq.push_back(x);
    #1;
  endtask

  task automatic run(input logic [7:0] r, input logic [7:0] m, input logic a, input int n);
    for (int i = 0; i < n; i++) step(r, m, a, 1'b0);
  endtask

  // Monitor: compare every DUT output against the next expected entry
  always @(negedge clk) begin
    exp_t x;
    if (sbq.size() > 0) begin
      x = sbq.pop_front();
      cmp("pend_o", ifc.pend_o, x.pend);
      cmp("en_o",   ifc.en_o,   x.en);
      cmp("irq_o",  ifc.irq_o,  x.irq);
      cmp("id_o",   ifc.id_o,   x.id);
      cmp("lost_o", ifc.lost_o, x.lost);
    end
  end

  initial begin
    logic [7:0] r, m;
    logic a, rs;
    // reset
    step(8'h00, 8'hFF, 1'b0, 1'b1);
    step(8'h00, 8'hFF, 1'b0, 1'b1);
    cmp("reset_irq", ifc.irq_o, 0);
    cmp("reset_lost", ifc.lost_o, 0);
    run(8'h00, 8'hFF, 1'b0, 4);

    // single request on line 3
    run(8'h08, 8'hFF, 1'b0, 5);
    cmp("single_irq", ifc.irq_o, 1);
    cmp("single_id", ifc.id_o, 3);
    cmp("single_pend", ifc.pend_o, 8'h08);
    cmp("single_en", ifc.en_o, 1);
    run(8'h08, 8'hFF, 1'b1, 1);
    run(8'h00, 8'hFF, 1'b0, 2);
    cmp("single_ack_pend", ifc.pend_o, 0);
    cmp("single_ack_irq", ifc.irq_o, 0);
    run(8'h00, 8'hFF, 1'b0, 2);

    // priority: 6 before 1, then 1 exactly two cycles after ack
    run(8'h42, 8'hFF, 1'b0, 5);
    cmp("prio_first", ifc.id_o, 6);
    run(8'h42, 8'hFF, 1'b1, 1);
    cmp("prio_gap_irq", ifc.irq_o, 0);
    run(8'h42, 8'hFF, 1'b1, 1);   // ack ignored in gap
    run(8'h42, 8'hFF, 1'b0, 1);
    cmp("prio_second_irq", ifc.irq_o, 1);
    cmp("prio_second_id", ifc.id_o, 1);
    run(8'h00, 8'hFF, 1'b1, 1);
    run(8'h00, 8'hFF, 1'b0, 3);

    // masking: line 0 latched but hidden, then revealed
    run(8'h01, 8'hFE, 1'b0, 6);
    cmp("mask_pend", ifc.pend_o, 0);
    cmp("mask_en", ifc.en_o, 0);
    cmp("mask_irq", ifc.irq_o, 0);
    run(8'h01, 8'hFF, 1'b0, 1);
    cmp("unmask_irq", ifc.irq_o, 1);
    cmp("unmask_id", ifc.id_o, 0);
    run(8'h00, 8'hFF, 1'b1, 1);
    run(8'h00, 8'hFF, 1'b0, 3);

    // collision: new edge on line 5 lands on the ack cycle of id 5
    run(8'h20, 8'hFF, 1'b0, 5);
    cmp("coll_id", ifc.id_o, 5);
    run(8'h00, 8'hFF, 1'b0, 3);
    run(8'h20, 8'hFF, 1'b0, 2);
    run(8'h20, 8'hFF, 1'b1, 1);
    run(8'h20, 8'hFF, 1'b0, 2);
    cmp("coll_reserve_irq", ifc.irq_o, 1);
    cmp("coll_reserve_id", ifc.id_o, 5);
    cmp("coll_lost", ifc.lost_o, 0);
    run(8'h00, 8'hFF, 1'b1, 1);
    run(8'h00, 8'hFF, 1'b0, 3);

    // loss counting: 20 edges on line 2, never acked
    for (int i = 0; i < 20; i++) begin
      run(8'h04, 8'hFF, 1'b0, 1);
      run(8'h00, 8'hFF, 1'b0, 1);
    end
    run(8'h00, 8'hFF, 1'b0, 3);
    cmp("lost_sat", ifc.lost_o, 15);
    step(8'h00, 8'hFF, 1'b0, 1'b1);
    cmp("lost_rst", ifc.lost_o, 0);
    cmp("lost_rst_irq", ifc.irq_o, 0);
    run(8'h00, 8'hFF, 1'b0, 4);

    // reset mid-service with the line held high
    run(8'h10, 8'hFF, 1'b0, 5);
    cmp("midrst_id", ifc.id_o, 4);
    cmp("midrst_irq", ifc.irq_o, 1);
    step(8'h10, 8'hFF, 1'b1, 1'b1);
    cmp("midrst_irq0", ifc.irq_o, 0);
    cmp("midrst_pend0", ifc.pend_o, 0);
    cmp("midrst_id0", ifc.id_o, 0);
    run(8'h10, 8'hFF, 1'b0, 8);
    cmp("midrst_noredetect", ifc.irq_o, 0);
    cmp("midrst_noredetect_en", ifc.en_o, 0);

    // randomized traffic
    r = 8'h00; m = 8'hFF;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 8; b++) if ($urandom_range(7) == 0) r[b] = ~r[b];
      if ($urandom_range(15) == 0) m = ($urandom_range(1) == 0) ? 8'hFF : 8'($urandom);
      a  = ($urandom_range(2) == 0);
      rs = ($urandom_range(499) == 0);
      step(r, m, a, rs);
    end

    repeat (2) @(negedge clk);
    cmp("scoreboard_drained", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/irq_pend_ctrl.md
IRQ_PEND_CTRL -- requirements
Module: irq_pend_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port req, input, 8 bits: asynchronous level request lines, bit 7 highest priority.
REQ-004 SHALL have port mask, input, 8 bits: 1 = line enabled for service, 0 = line latched but not presented.
REQ-005 SHALL have port ack, input, 1 bit: consumer acknowledge of the in-service request.
REQ-006 SHALL have port pend_o, output, 8 bits: pending AND mask, registered; drives the downstream 8-to-3 encoder input vector.
REQ-007 SHALL have port en_o, output, 1 bit: OR of pend_o, registered; drives the downstream encoder enable.
REQ-008 SHALL have port irq_o, output, 1 bit: request in service, awaiting ack.
REQ-009 SHALL have port id_o, output, 3 bits: index of the in-service line, stable while irq_o=1.
REQ-010 SHALL have port lost_o, output, 4 bits: saturating count of dropped edges.

Function
REQ-011 SHALL pass each req bit through a 2-flop synchronizer followed by an edge register, giving three flops per bit.
REQ-012 SHALL detect a rising edge as sync2 AND NOT edge_reg, so pending[n] is set on the 3rd rising clk after req[n] is first sampled high.
REQ-013 SHALL latch edges into pending[n] regardless of mask; mask gates only pend_o, en_o and selection.
REQ-014 SHALL update pend_o and en_o one cycle after pending or mask changes.
REQ-015 SHALL implement an FSM with states IDLE, SERVE and GAP.
REQ-016 SHALL, in IDLE with any (pending AND mask) bit set, load id_o with the highest set index and enter SERVE; irq_o=1 from the next cycle.
REQ-017 SHALL hold irq_o=1 and id_o stable in SERVE until ack=1; mask changes in SERVE SHALL NOT alter id_o.
REQ-018 SHALL, on ack=1 in SERVE, clear pending[id_o], deassert irq_o and enter GAP.
REQ-019 SHALL stay in GAP exactly one cycle, then return to IDLE with irq_o=0.
REQ-020 SHALL ignore ack in IDLE and GAP, with no state or pending change.
REQ-021 SHALL let a same-cycle new edge on bit id_o win over the ack clear: pending[id_o] stays set and lost_o is unchanged.
REQ-022 SHALL increment lost_o when an edge arrives on a bit already pending and not being cleared that cycle, except per REQ-021.
REQ-023 SHALL saturate lost_o at 15; it clears only on reset.
REQ-024 SHALL record edges arriving during SERVE/GAP in pending and serve them after the return to IDLE.
REQ-025 SHALL, after a completed service, give the earliest next irq_o assertion 2 cycles after the ack cycle (GAP, then IDLE select).

Reset
REQ-026 SHALL, on rst=1 at a clock edge, set the FSM to IDLE and clear pending, synchronizer, edge registers, pend_o, en_o, irq_o, id_o=3'b000 and lost_o.
REQ-027 SHALL treat rst as dominant over ack and edges in the same cycle; reset mid-SERVE drops the in-service request without a clear pulse.
REQ-028 SHALL, after reset release with req already high, NOT detect an edge, since edge_reg follows sync2 from reset.

Structure
REQ-029 SHALL place the FSM state encoding (IDLE, SERVE, GAP), the line count 8, the id width 3 and the lost-counter maximum 15 in a shared package.
REQ-030 SHALL use one sub-module, irq_edge_det, containing the per-bit synchronizer and edge register, instantiated once as an 8-bit vector.
REQ-031 SHALL perform highest-index selection as an in-module function; it SHALL NOT depend on the downstream encoder output.

Verification
REQ-032 SHALL cover single request: mask=8'hFF, req[3] raised -> pending set on 3rd edge, pend_o=8'h08, en_o=1, irq_o=1 with id_o=3; ack -> pend_o=0, irq_o=0.
REQ-033 SHALL cover priority: req[1] and req[6] raised together -> id_o=6 first; after ack and GAP, id_o=1.
REQ-034 SHALL cover masking: mask=8'hFE, req[0] raised -> pend_o=0, en_o=0, irq_o stays 0; then mask=8'hFF -> irq_o=1 with id_o=0.
REQ-035 SHALL cover collision: new edge on bit 5 in the same cycle as ack of id 5 -> pending[5] stays 1 and id 5 is served again.
REQ-036 SHALL cover loss count: 20 edges on req[2] with no ack -> lost_o=15 (saturated); rst=1 -> lost_o=0, irq_o=0.
REQ-037 SHALL cover reset mid-SERVE: irq_o=1 with id_o=4, rst pulse -> all outputs 0 next cycle; req[4] held high -> no re-detection.
